// File: rtl/game_port_timer.sv
// Game-port (201h) emulation: four one-shot axis timers and four buttons for two joysticks.
// Axis targets come from the analog value when nonzero, otherwise from the digital direction bits.

module game_port_axis #(
    parameter int CNT_W    = 11,
    parameter int CENTER   = 800,
    parameter int MIN_CNT  = 32,
    parameter int MAX_CNT  = 1564,
    parameter int ANA_GAIN = 6
) (
    input  logic [7:0]       ana_i,
    input  logic             neg_i,
    input  logic             pos_i,
    output logic [CNT_W-1:0] target_o
);
    localparam int TW = CNT_W + 2;
    localparam logic signed [TW-1:0] GAIN_S   = TW'(ANA_GAIN);
    localparam logic signed [TW-1:0] CENTER_S = TW'(CENTER);
    localparam logic signed [TW-1:0] MIN_S    = TW'(MIN_CNT);
    localparam logic signed [TW-1:0] MAX_S    = TW'(MAX_CNT);

    logic signed [TW-1:0] a_ext;
    logic signed [TW-1:0] scaled;

    always_comb begin
        a_ext  = {{(TW-8){ana_i[7]}}, ana_i};
        scaled = a_ext * GAIN_S + CENTER_S;
        if (ana_i != 8'd0) begin
            if (scaled < MIN_S)      target_o = CNT_W'(MIN_CNT);
            else if (scaled > MAX_S) target_o = CNT_W'(MAX_CNT);
            else                     target_o = scaled[CNT_W-1:0];
        end else if (neg_i) begin
            target_o = CNT_W'(MIN_CNT);
        end else if (pos_i) begin
            target_o = CNT_W'(MAX_CNT);
        end else begin
            target_o = CNT_W'(CENTER);
        end
    end
endmodule

module game_port_timer #(
    parameter int CNT_W    = 11,
    parameter int DIV      = 66,
    parameter int CENTER   = 800,
    parameter int MIN_CNT  = 32,
    parameter int MAX_CNT  = 1564,
    parameter int ANA_GAIN = 6,
    parameter int NUM_JOY  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  dig_1,
    input  logic [5:0]  dig_2,
    input  logic [15:0] ana_1,
    input  logic [15:0] ana_2,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable
);
    typedef enum logic {IDLE, COUNT} state_t;

    localparam int         DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0] EN_RST = (NUM_JOY == 2) ? 4'b1111 : 4'b0011;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]              en_q, en_d;
    logic [3:0][CNT_W-1:0]   tgt;
    logic [3:0][7:0]         ana_ax;
    logic [3:0]              neg, pos, ld_nz, ax;
    logic                    trig, tick;
    logic [1:0]              btn_1, btn_2;

    // Axis order J1X, J1Y, J2X, J2Y; LEFT/UP pull towards MIN, RIGHT/DOWN towards MAX.
    assign ana_ax = {ana_2[15:8], ana_2[7:0], ana_1[15:8], ana_1[7:0]};
    assign neg    = {dig_2[3], dig_2[1], dig_1[3], dig_1[1]};
    assign pos    = {dig_2[2], dig_2[0], dig_1[2], dig_1[0]};

    for (genvar g = 0; g < 4; g++) begin : g_axis
        game_port_axis #(
            .CNT_W(CNT_W), .CENTER(CENTER), .MIN_CNT(MIN_CNT),
            .MAX_CNT(MAX_CNT), .ANA_GAIN(ANA_GAIN)
        ) u_axis (
            .ana_i(ana_ax[g]), .neg_i(neg[g]), .pos_i(pos[g]), .target_o(tgt[g])
        );
    end

    always_comb begin
        en_d    = en_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        state_d = state_q;
        ld_nz   = '0;
        trig    = write && byteenable[1];
        tick    = (div_q == DIV_W'(DIV - 1));
        if (write && byteenable[2]) en_d = writedata[19:16];
        // A trigger overrides any tick on the same edge and uses the freshly written mask.
        if (trig) begin
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = en_d[i] ? tgt[i] : '0;
                ld_nz[i] = (cnt_d[i] != '0);
            end
            state_d = (|ld_nz) ? COUNT : IDLE;
            div_d   = (|ld_nz) ? DIV_W'(1) : '0;
        end else begin
            case (state_q)
                IDLE: div_d = '0;
                COUNT: begin
                    if (tick) begin
                        div_d = '0;
                        for (int i = 0; i < 4; i++)
                            if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                    if (cnt_d == '0) begin
                        state_d = IDLE;
                        div_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            en_q    <= EN_RST;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) ax[i] = en_q[i] ? (cnt_q[i] != '0) : 1'b1;
    end

    // A joystick with no enabled axis is treated as absent: buttons read released.
    assign btn_1 = (en_q[1:0] == 2'b00) ? 2'b11 : ~dig_1[5:4];
    assign btn_2 = (en_q[3:2] == 2'b00) ? 2'b11 : ~dig_2[5:4];

    assign readdata = {8'hFF, (state_q == COUNT), 3'b111, en_q, btn_2, btn_1, ax, 8'hFF};

    logic unused_bits;
    assign unused_bits = ^{writedata[31:20], writedata[15:0], byteenable[3], byteenable[0]};
endmodule

// File: tb/tb_game_port_timer.sv
// Bench for game_port_timer: expected axis/busy high times are queued at trigger time
// and popped against the durations observed on readdata.

module tb_game_port_timer;
    localparam int DIV_T = 4;
    localparam int BOUND = 1564 * DIV_T + 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  dig_1, dig_2;
    logic [15:0] ana_1, ana_2;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rd, rd8;

    typedef struct {string name; int exp;} exp_t;
    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic [3:0] mask_m;
    int   got[5];

    always #5 clk = ~clk;

    game_port_timer #(.DIV(DIV_T)) dut (
        .clk(clk), .rst_n(rst_n), .dig_1(dig_1), .dig_2(dig_2), .ana_1(ana_1), .ana_2(ana_2),
        .readdata(rd), .write(write), .writedata(writedata), .byteenable(byteenable));

    game_port_timer #(.DIV(DIV_T), .ANA_GAIN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .dig_1(dig_1), .dig_2(dig_2), .ana_1(ana_1), .ana_2(ana_2),
        .readdata(rd8), .write(write), .writedata(writedata), .byteenable(byteenable));

    function automatic int model_tgt(input logic [7:0] a, input logic neg, input logic pos, input int gain);
        int v;
        if (a != 8'd0) begin
            v = 800 + int'($signed(a)) * gain;
            if (v < 32) v = 32;
            if (v > 1564) v = 1564;
        end else if (neg) v = 32;
        else if (pos)     v = 1564;
        else              v = 800;
        return v;
    endfunction

    function automatic int axis_tgt(input int i, input int gain);
        case (i)
            0:       return model_tgt(ana_1[7:0],  dig_1[1], dig_1[0], gain);
            1:       return model_tgt(ana_1[15:8], dig_1[3], dig_1[2], gain);
            2:       return model_tgt(ana_2[7:0],  dig_2[1], dig_2[0], gain);
            default: return model_tgt(ana_2[15:8], dig_2[3], dig_2[2], gain);
        endcase
    endfunction

    task automatic trigger(input logic [3:0] be, input logic [31:0] wd, input bit push, input int gain);
        logic [3:0] en;
        int d, bmax;
        en = be[2] ? wd[19:16] : mask_m;
        if (be[2]) mask_m = wd[19:16];
        if (push && be[1]) begin
            bmax = 0;
            for (int i = 0; i < 4; i++) begin
                d = en[i] ? axis_tgt(i, gain) * DIV_T - 1 : -1;
                if (d > bmax) bmax = d;
                sb_q.push_back('{name: $sformatf("ax%0d", i), exp: d});
            end
            sb_q.push_back('{name: "busy", exp: bmax});
        end
        @(negedge clk);
        write = 1'b1; byteenable = be; writedata = wd;
        @(posedge clk);
        #1 write = 1'b0; byteenable = 4'h0; writedata = 32'h0;
    endtask

    // Counts high samples of ax0..3 and busy; -1 means still high when monitoring stopped.
    task automatic measure(input int sel);
        int hi[5] = '{default: 0};
        bit done[5] = '{default: 0};
        bit fin;
        logic [31:0] r;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            r = (sel != 0) ? rd8 : rd;
            for (int k = 0; k < 4; k++)
                if (!done[k]) begin
                    if (r[8+k]) hi[k]++; else done[k] = 1'b1;
                end
            if (!done[4]) begin
                if (r[23]) hi[4]++; else done[4] = 1'b1;
            end
            fin = done[4];
            for (int k = 0; k < 4; k++) if (mask_m[k] && !done[k]) fin = 1'b0;
            if (fin) break;
        end
        for (int k = 0; k < 5; k++) got[k] = done[k] ? hi[k] : -1;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        e = {8'hFF, 1'b0, 3'b111, 4'hF, ~dig_2[5:4], ~dig_1[5:4], 4'h0, 8'hFF};
        n_chk++;
        if (rd !== e) begin n_fail++; $display("FAIL reset_word: got %h expected %h", rd, e); end
    endtask

    task automatic test_center;
        exp_t e;
        trigger(4'b0010, 32'h0, 1'b1, 6);
        measure(0);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front(); n_chk++;
            if (got[k] != e.exp) begin n_fail++; $display("FAIL center_%s: got %0d expected %0d", e.name, got[k], e.exp); end
        end
    endtask

    task automatic test_digital;
        exp_t e;
        @(negedge clk);
        dig_1 = 6'b011010; dig_2 = 6'b000001;
        #1 n_chk++;
        if (rd[15:12] !== 4'b1110) begin n_fail++; $display("FAIL buttons: got %b expected 1110", rd[15:12]); end
        trigger(4'b0010, 32'h0, 1'b1, 6);
        measure(0);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front(); n_chk++;
            if (got[k] != e.exp) begin n_fail++; $display("FAIL digital_%s: got %0d expected %0d", e.name, got[k], e.exp); end
        end
    endtask

    task automatic test_analog;
        exp_t e;
        @(negedge clk);
        dig_1 = 6'b000010; dig_2 = 6'b0;
        ana_1 = {8'h7F, 8'h80}; ana_2 = {8'hF6, 8'h40};
        trigger(4'b0010, 32'h0, 1'b1, 6);
        measure(0);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front(); n_chk++;
            if (got[k] != e.exp) begin n_fail++; $display("FAIL analog_%s: got %0d expected %0d", e.name, got[k], e.exp); end
        end
    endtask

    task automatic test_gain;
        exp_t e;
        @(negedge clk);
        dig_1 = 6'b0; ana_1 = {8'h00, 8'h7F}; ana_2 = 16'h0;
        trigger(4'b0010, 32'h0, 1'b1, 8);
        measure(1);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front(); n_chk++;
            if (got[k] != e.exp) begin n_fail++; $display("FAIL gain8_%s: got %0d expected %0d", e.name, got[k], e.exp); end
        end
    endtask

    task automatic test_mask;
        exp_t e;
        @(negedge clk);
        ana_1 = 16'h0; dig_2 = 6'b110000;
        trigger(4'b0100, 32'h0003_0000, 1'b0, 6);
        @(negedge clk);
        n_chk++;
        if (rd[19:16] !== 4'b0011) begin n_fail++; $display("FAIL mask_readback: got %b expected 0011", rd[19:16]); end
        n_chk++;
        if (rd[15:14] !== 2'b11) begin n_fail++; $display("FAIL mask_j2_buttons: got %b expected 11", rd[15:14]); end
        n_chk++;
        if (rd[11:10] !== 2'b11) begin n_fail++; $display("FAIL mask_j2_axes: got %b expected 11", rd[11:10]); end
        trigger(4'b0010, 32'h0, 1'b1, 6);
        measure(0);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front(); n_chk++;
            if (got[k] != e.exp) begin n_fail++; $display("FAIL mask_%s: got %0d expected %0d", e.name, got[k], e.exp); end
        end
    endtask

    task automatic test_both;
        exp_t e;
        trigger(4'b0110, 32'h000F_0000, 1'b1, 6);
        measure(0);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front(); n_chk++;
            if (got[k] != e.exp) begin n_fail++; $display("FAIL both_%s: got %0d expected %0d", e.name, got[k], e.exp); end
        end
        n_chk++;
        if (rd[15:14] !== 2'b00) begin n_fail++; $display("FAIL both_j2_buttons: got %b expected 00", rd[15:14]); end
    endtask

    task automatic test_zero_mask;
        exp_t e;
        @(negedge clk);
        dig_1 = 6'b110000;
        trigger(4'b0110, 32'h0000_0000, 1'b1, 6);
        measure(0);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front(); n_chk++;
            if (got[k] != e.exp) begin n_fail++; $display("FAIL zero_%s: got %0d expected %0d", e.name, got[k], e.exp); end
        end
        n_chk++;
        if (rd[15:8] !== 8'hFF) begin n_fail++; $display("FAIL zero_word: got %h expected ff", rd[15:8]); end
        trigger(4'b0100, 32'h000F_0000, 1'b0, 6);
        dig_1 = 6'b0; dig_2 = 6'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        trigger(4'b0010, 32'h0, 1'b0, 6);
        repeat (1598) @(posedge clk);
        #1 n_chk++;
        if (rd[23] !== 1'b1 || rd[11:8] !== 4'hF) begin
            n_fail++; $display("FAIL midcount: got busy=%b ax=%b expected busy=1 ax=1111", rd[23], rd[11:8]);
        end
        dig_1 = 6'b000001; dig_2 = 6'b001000;
        trigger(4'b0010, 32'h0, 1'b1, 6);
        measure(0);
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front(); n_chk++;
            if (got[k] != e.exp) begin n_fail++; $display("FAIL retrig_%s: got %0d expected %0d", e.name, got[k], e.exp); end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        dig_1 = 6'b010000; dig_2 = 6'b0;
        trigger(4'b0110, 32'h0003_0000, 1'b0, 6);
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 n_chk++;
        if (rd[23] !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", rd[23]); end
        n_chk++;
        if (rd[15:8] !== 8'b1110_0000) begin n_fail++; $display("FAIL rst_bits: got %b expected 11100000", rd[15:8]); end
        n_chk++;
        if (rd[19:16] !== 4'hF) begin n_fail++; $display("FAIL rst_mask: got %b expected 1111", rd[19:16]); end
        @(negedge clk);
        rst_n = 1'b1; mask_m = 4'hF;
        repeat (5) @(negedge clk);
        n_chk++;
        if (rd !== 32'hFF7F_E0FF) begin n_fail++; $display("FAIL post_rst_word: got %h expected ff7fe0ff", rd); end
    endtask

    initial begin
        rst_n = 1'b0; dig_1 = 6'b0; dig_2 = 6'b0; ana_1 = 16'h0; ana_2 = 16'h0;
        write = 1'b0; writedata = 32'h0; byteenable = 4'h0; mask_m = 4'hF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_center;
        test_digital;
        test_analog;
        test_gain;
        test_mask;
        test_both;
        test_zero_mask;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
